// File: rtl/phase_addr_gen.sv
// rtl/phase_addr_gen.sv - shared phase accumulator with per-channel offset ROM addresses
module phase_addr_gen #(
  parameter int WIDTH    = 9,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WIDTH-1:0]          step,
  input  logic [1:0]                mode,
  input  logic                      ld,
  input  logic [WIDTH-1:0]          ld_val,
  input  logic [CHANNELS*WIDTH-1:0] offset,
  output logic [WIDTH-1:0]          count,
  output logic [CHANNELS*WIDTH-1:0] addr,
  output logic                      wrap,
  output logic                      addr_valid
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  logic [WIDTH-1:0]          count_q, count_d;
  dir_t                      dir_q, dir_d;
  logic                      wrap_q, wrap_d;
  logic [CHANNELS*WIDTH-1:0] addr_q, addr_d;
  logic                      addr_valid_q, addr_valid_d;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] max_c;

  assign max_c   = '1;
  assign sum_ext = {1'b0, count_q} + {1'b0, step};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      dir_q        <= DIR_UP;
      wrap_q       <= 1'b0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      dir_q        <= dir_d;
      wrap_q       <= wrap_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
    end
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (ld) begin
      count_d = ld_val;
      dir_d   = DIR_UP;
    end else begin
      // Outside bounce the direction is meaningless; parking it UP makes bounce entry start upward.
      if (mode != MODE_BOUNCE) dir_d = DIR_UP;
      if (en && (step != '0)) begin
        case (mode)
          MODE_UP: begin
            count_d = sum_ext[WIDTH-1:0];
            wrap_d  = sum_ext[WIDTH];
          end
          MODE_DOWN: begin
            count_d = count_q - step;
            wrap_d  = (step > count_q);
          end
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (step > (max_c - count_q)) begin
                count_d = max_c;
                dir_d   = DIR_DOWN;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q + step;
              end
            end else begin
              if (step > count_q) begin
                count_d = '0;
                dir_d   = DIR_UP;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q - step;
              end
            end
          end
          default: begin
            count_d = count_q;
          end
        endcase
      end
    end
  end

  always_comb begin
    addr_d       = '0;
    addr_valid_d = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      addr_d[k*WIDTH +: WIDTH] = count_q - offset[k*WIDTH +: WIDTH];
    end
  end

  assign count      = count_q;
  assign wrap       = wrap_q;
  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;

endmodule

// File: tb/tb_phase_addr_gen.sv
// tb/tb_phase_addr_gen.sv - directed scoreboard bench for phase_addr_gen (WIDTH=4, CHANNELS=2)
module tb_phase_addr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] step;
  logic [1:0] mode;
  logic       ld;
  logic [3:0] ld_val;
  logic [7:0] offset;
  logic [3:0] count;
  logic [7:0] addr;
  logic       wrap;
  logic       addr_valid;

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic       wrp;
    logic [7:0] adr;
    logic       vld;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [3:0] prev_cnt;

  phase_addr_gen #(.WIDTH(4), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .step(step), .mode(mode), .ld(ld),
    .ld_val(ld_val), .offset(offset), .count(count), .addr(addr),
    .wrap(wrap), .addr_valid(addr_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one cycle; the expected count/wrap come from the caller, addr from the previous expected count.
  task automatic cyc(input string tag, input bit e, input logic [3:0] s, input logic [1:0] m,
                     input bit l, input logic [3:0] lv, input logic [3:0] ec, input bit ew);
    exp_t       x;
    logic [3:0] a0, a1;
    en = e; step = s; mode = m; ld = l; ld_val = lv;
    a0 = prev_cnt - offset[3:0];
    a1 = prev_cnt - offset[7:4];
    x.tag = tag; x.cnt = ec; x.wrp = ew; x.adr = {a1, a0}; x.vld = 1'b1;
    sb.push_back(x);
    prev_cnt = ec;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".count"}, 32'(count), 32'(x.cnt));
    chk({x.tag, ".wrap"},  32'(wrap),  32'(x.wrp));
    chk({x.tag, ".addr"},  32'(addr),  32'(x.adr));
    chk({x.tag, ".valid"}, 32'(addr_valid), 32'(x.vld));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".wrap"},  32'(wrap),  32'd0);
    chk({tag, ".addr"},  32'(addr),  32'd0);
    chk({tag, ".valid"}, 32'(addr_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; step = '0; mode = 2'b00; ld = 1'b0; ld_val = '0;
    offset = {4'd3, 4'd0};
    prev_cnt = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 1; i <= 17; i++)
      cyc($sformatf("up1_%0d", i), 1, 4'd1, 2'b00, 0, 4'd0, 4'(i % 16), (i % 16) == 0);

    cyc("ld0_a", 1, 4'd5, 2'b00, 1, 4'd0, 4'd0, 0);
    cyc("up5_1", 1, 4'd5, 2'b00, 0, 4'd0, 4'd5, 0);
    cyc("up5_2", 1, 4'd5, 2'b00, 0, 4'd0, 4'd10, 0);
    cyc("up5_3", 1, 4'd5, 2'b00, 0, 4'd0, 4'd15, 0);
    cyc("up5_4", 1, 4'd5, 2'b00, 0, 4'd0, 4'd4, 1);

    cyc("ld2",   0, 4'd3, 2'b01, 1, 4'd2, 4'd2, 0);
    cyc("dn3_1", 1, 4'd3, 2'b01, 0, 4'd0, 4'd15, 1);
    cyc("dn3_2", 1, 4'd3, 2'b01, 0, 4'd0, 4'd12, 0);

    cyc("ld0_b", 0, 4'd0, 2'b10, 1, 4'd0, 4'd0, 0);
    cyc("bn6_1", 1, 4'd6, 2'b10, 0, 4'd0, 4'd6, 0);
    cyc("bn6_2", 1, 4'd6, 2'b10, 0, 4'd0, 4'd12, 0);
    cyc("bn6_3", 1, 4'd6, 2'b10, 0, 4'd0, 4'd15, 1);
    cyc("bn6_4", 1, 4'd6, 2'b10, 0, 4'd0, 4'd9, 0);
    cyc("bn6_5", 1, 4'd6, 2'b10, 0, 4'd0, 4'd3, 0);
    cyc("bn6_6", 1, 4'd6, 2'b10, 0, 4'd0, 4'd0, 1);
    cyc("bn6_7", 1, 4'd6, 2'b10, 0, 4'd0, 4'd6, 0);
    cyc("bn0_1", 1, 4'd0, 2'b10, 0, 4'd0, 4'd6, 0);
    cyc("bn0_2", 1, 4'd0, 2'b00, 0, 4'd0, 4'd6, 0);

    cyc("bn6_8", 1, 4'd6, 2'b10, 0, 4'd0, 4'd12, 0);
    cyc("bn6_9", 1, 4'd6, 2'b10, 0, 4'd0, 4'd15, 1);
    cyc("ld7en", 1, 4'd6, 2'b10, 1, 4'd7, 4'd7, 0);
    cyc("bn1",   1, 4'd1, 2'b10, 0, 4'd0, 4'd8, 0);

    cyc("hold11", 1, 4'd3, 2'b11, 0, 4'd0, 4'd8, 0);
    offset = {4'd5, 4'd2};
    cyc("offchg", 0, 4'd3, 2'b00, 0, 4'd0, 4'd8, 0);

    cyc("ld0_c", 0, 4'd0, 2'b01, 1, 4'd0, 4'd0, 0);
    cyc("cw_1",  1, 4'd15, 2'b01, 0, 4'd0, 4'd1, 1);
    cyc("cw_2",  1, 4'd15, 2'b01, 0, 4'd0, 4'd2, 1);

    cyc("ld15",  0, 4'd0, 2'b10, 1, 4'd15, 4'd15, 0);
    cyc("max_1", 1, 4'd1, 2'b10, 0, 4'd0, 4'd15, 1);
    cyc("max_2", 1, 4'd1, 2'b10, 0, 4'd0, 4'd14, 0);
    cyc("min_1", 1, 4'd14, 2'b10, 0, 4'd0, 4'd0, 0);
    cyc("min_2", 1, 4'd14, 2'b10, 0, 4'd0, 4'd0, 1);
    cyc("min_3", 1, 4'd14, 2'b10, 0, 4'd0, 4'd14, 0);
    cyc("pre_r", 1, 4'd6, 2'b10, 0, 4'd0, 4'd15, 1);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    #2;
    rst = 1'b0;
    prev_cnt = 4'd0;
    cyc("post_1", 1, 4'd6, 2'b10, 0, 4'd0, 4'd6, 0);
    cyc("post_2", 1, 4'd6, 2'b10, 0, 4'd0, 4'd12, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
